// File: rtl/sd_boot_pkg.sv
// Shared types and SD register map for the boot sequencer that copies SD
// sectors into RAM.
package sd_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_DONE,
        ST_WAIT_IDLE,
        ST_SET_ADDR,
        ST_START,
        ST_WAIT_DONE,
        ST_SET_PAGE,
        ST_XFER,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] ADDR0  = 8'h00;
    localparam logic [7:0] BUSY   = 8'h04;
    localparam logic [7:0] RSTART = 8'h05;
    localparam logic [7:0] PAGE   = 8'h07;
    localparam logic [7:0] DONE   = 8'h0A;
    localparam logic [7:0] BUF    = 8'h80;

    localparam int PAGES      = 4;
    localparam int PAGE_BYTES = 128;

endpackage

// File: rtl/sd_boot_loader.sv
// Drives the SD interface register bus to copy a run of sectors into RAM.
// Bus outputs are registered and describe the access of the current state.
module sd_boot_loader
    import sd_boot_pkg::*;
#(
    parameter logic [31:0] SECTOR_START   = 32'd0,
    parameter logic [7:0]  SECTOR_COUNT   = 8'd16,
    parameter logic [15:0] LOAD_ADDR      = 16'h0200,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        sd_cs_o,
    output logic        sd_rw_n_o,
    output logic [7:0]  sd_addr_o,
    output logic [7:0]  sd_wdata_o,
    input  logic [7:0]  sd_rdata_i,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    output logic        mem_we_o
);

    localparam logic [1:0]  LAST_PAGE = 2'(PAGES - 1);
    localparam logic [6:0]  LAST_IDX  = 7'(PAGE_BYTES - 1);
    localparam logic [23:0] TMO_LAST  = TIMEOUT_CYCLES - 24'd1;

    state_t      state_reg;
    logic [31:0] sect_reg;
    logic [7:0]  remaining_reg;
    logic [15:0] maddr_reg;
    logic [1:0]  page_reg;
    logic [6:0]  idx_reg;
    logic [23:0] tmo_reg;
    logic        busy_reg, done_reg, error_reg;
    logic        cs_reg, rw_n_reg, we_reg;
    logic [7:0]  addr_reg, wdata_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            sect_reg      <= '0;
            remaining_reg <= '0;
            maddr_reg     <= '0;
            page_reg      <= '0;
            idx_reg       <= '0;
            tmo_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            cs_reg        <= 1'b0;
            rw_n_reg      <= 1'b1;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            // Idle bus unless the next state issues an access below.
            cs_reg    <= 1'b0;
            rw_n_reg  <= 1'b1;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        sect_reg      <= SECTOR_START;
                        remaining_reg <= SECTOR_COUNT;
                        maddr_reg     <= LOAD_ADDR;
                        page_reg      <= '0;
                        idx_reg       <= '0;
                        tmo_reg       <= '0;
                        error_reg     <= 1'b0;
                        if (SECTOR_COUNT == 8'd0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_CLR_DONE;
                            done_reg  <= 1'b0;
                            busy_reg  <= 1'b1;
                            cs_reg    <= 1'b1;
                            addr_reg  <= DONE;
                        end
                    end
                end
                ST_CLR_DONE: begin
                    state_reg <= ST_WAIT_IDLE;
                    tmo_reg   <= '0;
                    cs_reg    <= 1'b1;
                    addr_reg  <= BUSY;
                end
                ST_WAIT_IDLE: begin
                    if (!sd_rdata_i[0]) begin
                        state_reg <= ST_SET_ADDR;
                        idx_reg   <= '0;
                        cs_reg    <= 1'b1;
                        rw_n_reg  <= 1'b0;
                        addr_reg  <= ADDR0;
                        wdata_reg <= sect_reg[7:0];
                    end else if (tmo_reg == TMO_LAST) begin
                        state_reg <= ST_ERROR;
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        tmo_reg  <= tmo_reg + 24'd1;
                        cs_reg   <= 1'b1;
                        addr_reg <= BUSY;
                    end
                end
                ST_SET_ADDR: begin
                    cs_reg   <= 1'b1;
                    rw_n_reg <= 1'b0;
                    if (idx_reg[1:0] == 2'd3) begin
                        state_reg <= ST_START;
                        addr_reg  <= RSTART;
                    end else begin
                        idx_reg   <= idx_reg + 7'd1;
                        addr_reg  <= ADDR0 + {6'd0, idx_reg[1:0] + 2'd1};
                        wdata_reg <= sect_reg[{idx_reg[1:0] + 2'd1, 3'b000} +: 8];
                    end
                end
                ST_START: begin
                    state_reg <= ST_WAIT_DONE;
                    tmo_reg   <= '0;
                    cs_reg    <= 1'b1;
                    addr_reg  <= DONE;
                end
                ST_WAIT_DONE: begin
                    if (sd_rdata_i[0]) begin
                        state_reg <= ST_SET_PAGE;
                        page_reg  <= '0;
                        cs_reg    <= 1'b1;
                        rw_n_reg  <= 1'b0;
                        addr_reg  <= PAGE;
                    end else if (tmo_reg == TMO_LAST) begin
                        state_reg <= ST_ERROR;
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        tmo_reg  <= tmo_reg + 24'd1;
                        cs_reg   <= 1'b1;
                        addr_reg <= DONE;
                    end
                end
                ST_SET_PAGE: begin
                    state_reg <= ST_XFER;
                    idx_reg   <= '0;
                    cs_reg    <= 1'b1;
                    addr_reg  <= BUF;
                    we_reg    <= 1'b1;
                end
                ST_XFER: begin
                    // maddr_reg is the address of the byte written this cycle.
                    maddr_reg <= maddr_reg + 16'd1;
                    if (idx_reg == LAST_IDX) begin
                        if (page_reg != LAST_PAGE) begin
                            state_reg <= ST_SET_PAGE;
                            page_reg  <= page_reg + 2'd1;
                            cs_reg    <= 1'b1;
                            rw_n_reg  <= 1'b0;
                            addr_reg  <= PAGE;
                            wdata_reg <= {6'd0, page_reg + 2'd1};
                        end else begin
                            state_reg <= ST_NEXT;
                        end
                    end else begin
                        idx_reg  <= idx_reg + 7'd1;
                        cs_reg   <= 1'b1;
                        addr_reg <= BUF | {1'b0, idx_reg + 7'd1};
                        we_reg   <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    sect_reg      <= sect_reg + 32'd1;
                    remaining_reg <= remaining_reg - 8'd1;
                    if (remaining_reg == 8'd1) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= ST_CLR_DONE;
                        cs_reg    <= 1'b1;
                        addr_reg  <= DONE;
                    end
                end
                ST_DONE:  state_reg <= ST_IDLE;
                ST_ERROR: state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign error_o    = error_reg;
    assign sd_cs_o    = cs_reg;
    assign sd_rw_n_o  = rw_n_reg;
    assign sd_addr_o  = addr_reg;
    assign sd_wdata_o = wdata_reg;
    assign mem_we_o   = we_reg;
    assign mem_addr_o = maddr_reg;
    // The SD buffer presents data in the same cycle as its address.
    assign mem_data_o = we_reg ? sd_rdata_i : 8'h00;

endmodule

// File: tb/tb_sd_boot_loader.sv
// Bench for sd_boot_loader: SD card model, RAM write scoreboard and a
// zero-sector instance for the immediate-finish path.
module tb_sd_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic        busy_a, done_a, error_a, sd_cs_a, sd_rw_n_a, mem_we_a;
    logic [7:0]  sd_addr_a, sd_wdata_a, sd_rdata_a, mem_data_a;
    logic [15:0] mem_addr_a;

    logic        start_b = 1'b0;
    logic        busy_b, done_b, error_b, sd_cs_b, sd_rw_n_b, mem_we_b;
    logic [7:0]  sd_addr_b, sd_wdata_b, mem_data_b;
    logic [15:0] mem_addr_b;

    sd_boot_loader #(
        .SECTOR_START(32'h0000_00FF), .SECTOR_COUNT(8'd3),
        .LOAD_ADDR(16'hFF00), .TIMEOUT_CYCLES(24'd100)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .busy_o(busy_a), .done_o(done_a), .error_o(error_a),
        .sd_cs_o(sd_cs_a), .sd_rw_n_o(sd_rw_n_a), .sd_addr_o(sd_addr_a),
        .sd_wdata_o(sd_wdata_a), .sd_rdata_i(sd_rdata_a),
        .mem_addr_o(mem_addr_a), .mem_data_o(mem_data_a), .mem_we_o(mem_we_a)
    );

    sd_boot_loader #(
        .SECTOR_START(32'd7), .SECTOR_COUNT(8'd0),
        .LOAD_ADDR(16'h0200), .TIMEOUT_CYCLES(24'd100)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .busy_o(busy_b), .done_o(done_b), .error_o(error_b),
        .sd_cs_o(sd_cs_b), .sd_rw_n_o(sd_rw_n_b), .sd_addr_o(sd_addr_b),
        .sd_wdata_o(sd_wdata_b), .sd_rdata_i(8'h00),
        .mem_addr_o(mem_addr_b), .mem_data_o(mem_data_b), .mem_we_o(mem_we_b)
    );

    // SD card model: sector/page registers, busy counter, read-to-clear done.
    logic [31:0] sec_m = '0;
    logic [1:0]  page_m = '0;
    int          busy_cnt = 0;
    int          done_timer = 0;
    logic        done_m = 1'b0;
    int          pre_hold = 0;
    logic        preload_done = 1'b0;
    logic        never_done = 1'b0;

    always_comb begin
        sd_rdata_a = 8'h00;
        if (sd_addr_a == 8'h04)      sd_rdata_a = {7'd0, busy_cnt != 0};
        else if (sd_addr_a == 8'h0A) sd_rdata_a = {7'd0, done_m};
        else if (sd_addr_a[7])       sd_rdata_a = {page_m[0], sd_addr_a[6:0]} ^ 8'h5A ^ sec_m[7:0];
    end

    always @(posedge clk) begin
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (done_timer > 0) done_timer <= done_timer - 1;
        if (sd_cs_a && sd_rw_n_a && sd_addr_a == 8'h0A) done_m <= 1'b0;
        if (done_timer == 1) done_m <= 1'b1;
        if (start_a && !busy_a) begin
            busy_cnt <= pre_hold;
            done_m   <= preload_done;
        end
        if (sd_cs_a && !sd_rw_n_a) begin
            if (sd_addr_a <= 8'h03) sec_m[sd_addr_a[1:0]*8 +: 8] <= sd_wdata_a;
            if (sd_addr_a == 8'h07) page_m <= sd_wdata_a[1:0];
            if (sd_addr_a == 8'h05) begin
                busy_cnt   <= 3;
                done_timer <= never_done ? 0 : 8;
            end
        end
    end

    int          n_assert = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    logic [31:0] sect_q[$];
    int          we_count = 0;
    int          starts = 0;
    int          reads_0a = 0;
    int          cs_b_count = 0;
    logic        after_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_load(input int nbytes);
        logic [31:0] s;
        logic [8:0]  b;
        logic [15:0] a;
        for (int k = 0; k < nbytes; k++) begin
            s = 32'h0000_00FF + 32'(k / 512);
            b = 9'(k % 512);
            a = 16'hFF00 + 16'(k);
            exp_q.push_back({a, b[7:0] ^ 8'h5A ^ s[7:0]});
        end
    endtask

    task automatic monitor();
        logic [23:0] e;
        logic [31:0] es;
        forever begin
            @(negedge clk);
            if (mem_we_a) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    check("mem_we_unexpected", {16'd0, mem_addr_a}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_addr", {16'd0, mem_addr_a}, {16'd0, e[23:8]});
                    check("mem_data", {24'd0, mem_data_a}, {24'd0, e[7:0]});
                end
            end
            if (sd_cs_a && !sd_rw_n_a && sd_addr_a == 8'h05) begin
                starts++;
                reads_0a = 0;
                after_start = 1'b1;
                check("busy_at_rstart", {31'd0, busy_cnt != 0}, 32'd0);
                es = (sect_q.size() != 0) ? sect_q.pop_front() : 32'hDEAD_BEEF;
                check("sector_addr", sec_m, es);
            end
            if (sd_cs_a && !sd_rw_n_a && sd_addr_a == 8'h07) after_start = 1'b0;
            if (sd_cs_a && sd_rw_n_a && sd_addr_a == 8'h0A) begin
                reads_0a++;
                if (after_start && sd_rdata_a[0])
                    check("stale_done_skipped", {31'd0, reads_0a > 1}, 32'd1);
            end
            if (sd_cs_b) cs_b_count++;
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int cyc = 0;
        while (!done_a && !error_a && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int base;
        int cyc;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_error", {31'd0, error_a}, 32'd0);
        check("rst_cs", {31'd0, sd_cs_a}, 32'd0);
        check("rst_rw_n", {31'd0, sd_rw_n_a}, 32'd1);
        check("rst_we", {31'd0, mem_we_a}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr_a}, 32'd0);
        check("rst_sd_addr", {24'd0, sd_addr_a}, 32'd0);
        check("rst_done_b", {31'd0, done_b}, 32'd0);
        rst = 1'b0;

        // Three sectors from 0xFF with address wrap, held busy and a stale done
        pre_hold = 50;
        preload_done = 1'b1;
        push_load(1536);
        sect_q.push_back(32'hFF); sect_q.push_back(32'h100); sect_q.push_back(32'h101);
        base = we_count;
        pulse_start_a();
        #1;
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        cyc = 0;
        while (we_count < base + 100 && cyc < 5000) begin @(negedge clk); #1; cyc++; end
        pulse_start_a();
        wait_end(10000);
        check("load_done", {31'd0, done_a}, 32'd1);
        check("load_busy", {31'd0, busy_a}, 32'd0);
        check("load_error", {31'd0, error_a}, 32'd0);
        check("load_rstarts", 32'(starts), 32'd3);
        check("load_bytes", 32'(we_count - base), 32'd1536);
        check("load_queue_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        check("done_sticky", {31'd0, done_a}, 32'd1);
        check("idle_cs", {31'd0, sd_cs_a}, 32'd0);

        // Timeout in WAIT_DONE
        pre_hold = 0;
        preload_done = 1'b0;
        never_done = 1'b1;
        sect_q.push_back(32'hFF);
        base = we_count;
        pulse_start_a();
        #1;
        check("tmo_done_cleared", {31'd0, done_a}, 32'd0);
        wait_end(2000);
        check("tmo_error", {31'd0, error_a}, 32'd1);
        check("tmo_busy", {31'd0, busy_a}, 32'd0);
        check("tmo_done", {31'd0, done_a}, 32'd0);
        check("tmo_wait_reads", 32'(reads_0a), 32'd100);
        check("tmo_no_writes", 32'(we_count - base), 32'd0);
        @(negedge clk); #1;
        check("tmo_idle_cs", {31'd0, sd_cs_a}, 32'd0);

        // Restart clears error; reset after 200 RAM writes
        never_done = 1'b0;
        push_load(200);
        sect_q.push_back(32'hFF);
        base = we_count;
        pulse_start_a();
        #1;
        check("restart_error_cleared", {31'd0, error_a}, 32'd0);
        check("restart_busy", {31'd0, busy_a}, 32'd1);
        cyc = 0;
        while (we_count < base + 200 && cyc < 5000) begin @(negedge clk); #1; cyc++; end
        check("pre_reset_writes", 32'(we_count - base), 32'd200);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_cs", {31'd0, sd_cs_a}, 32'd0);
        check("midrst_rw_n", {31'd0, sd_rw_n_a}, 32'd1);
        check("midrst_we", {31'd0, mem_we_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full reload after reset
        starts = 0;
        push_load(1536);
        sect_q.push_back(32'hFF); sect_q.push_back(32'h100); sect_q.push_back(32'h101);
        base = we_count;
        pulse_start_a();
        wait_end(10000);
        check("reload_done", {31'd0, done_a}, 32'd1);
        check("reload_bytes", 32'(we_count - base), 32'd1536);
        check("reload_rstarts", 32'(starts), 32'd3);

        // Zero-sector instance finishes immediately without SD access
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        #1;
        check("zero_done", {31'd0, done_b}, 32'd1);
        check("zero_busy", {31'd0, busy_b}, 32'd0);
        check("zero_we", {31'd0, mem_we_b}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("zero_sd_access", 32'(cs_b_count), 32'd0);
        check("zero_done_sticky", {31'd0, done_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_boot_loader.md
Name: sd_boot_loader

Overview:
Hardware sequencer that sits upstream of the SD-card register interface and drives its CPU-side register bus in place of the 6502. On start it copies a contiguous run of 512-byte sectors into system RAM through a simple byte write port. The top-level mux gives it the SD interface and the RAM port while busy_o is high, e.g. to load the boot image before the CPU leaves reset.

Parameters:
SECTOR_START, 32'd0, first SD sector loaded.
SECTOR_COUNT, 8'd16, number of sectors to load; 0 means finish immediately.
LOAD_ADDR, 16'h0200, RAM byte address of the first loaded byte.
TIMEOUT_CYCLES, 24'd10_000_000, maximum clk_i cycles spent in any one wait state before an error is raised.

Ports:
clk_i  in  1  system clock, the only clock.
rst_i  in  1  reset, synchronous, active-high.
start_i  in  1  single-cycle pulse that begins a load; ignored while busy_o=1.
busy_o  out  1  high from the cycle after an accepted start until DONE or ERROR is reached.
done_o  out  1  sticky high after a successful load; cleared by an accepted start.
error_o  out  1  sticky high after a timeout; cleared by an accepted start.
sd_cs_o  out  1  select to the SD interface.
sd_rw_n_o  out  1  1 = read, 0 = write.
sd_addr_o  out  8  SD register address.
sd_wdata_o  out  8  SD write data.
sd_rdata_i  in  8  SD read data.
mem_addr_o  out  16  RAM byte address.
mem_data_o  out  8  RAM write data.
mem_we_o  out  1  RAM write strobe, one cycle per byte.

Behaviour:
- Reset values:
  - All outputs 0, except sd_rw_n_o=1.
  - State is IDLE; counters are 0.
- Idle bus: sd_cs_o=0, sd_rw_n_o=1. Every SD access is exactly one cycle with sd_cs_o=1.
- SD register reads: sd_rdata_i is sampled in the same cycle the address is presented (the buffer is clocked on the falling edge).
- Working registers:
  - sect, 32 bit, loaded with SECTOR_START.
  - remaining, 8 bit, loaded with SECTOR_COUNT.
  - maddr, 16 bit, loaded with LOAD_ADDR.
  - page, 2 bit.
  - idx, 7 bit.
  - tmo, 24 bit.
- FSM states and transitions:
  - IDLE: on start_i, load the working registers and clear done_o and error_o. If remaining=0, go to DONE; otherwise go to CLR_DONE.
  - CLR_DONE: one read of register 0x0A to discard any stale done latch. Go to WAIT_IDLE.
  - WAIT_IDLE: read register 0x04 every cycle until bit0=0, then go to SET_ADDR.
  - SET_ADDR: four consecutive writes to 0x00..0x03 with sect[7:0]..sect[31:24]. Go to START.
  - START: write 0x00 to register 0x05. Go to WAIT_DONE.
  - WAIT_DONE: read register 0x0A every cycle until bit0=1. Set page=0, go to SET_PAGE.
  - SET_PAGE: write {6'd0, page} to register 0x07. Set idx=0, go to XFER.
  - XFER, once per byte:
    - Read register 0x80|idx.
    - Same cycle: mem_we_o=1, mem_addr_o=maddr, mem_data_o=sd_rdata_i.
    - maddr increments by 1 and wraps 0xFFFF -> 0x0000 with no error.
    - idx increments. When idx=127: if page<3, increment page and go to SET_PAGE; otherwise go to NEXT.
  - NEXT: sect+1 (32-bit wrap), remaining-1. If remaining is now 0, go to DONE; otherwise go to CLR_DONE.
  - DONE: done_o=1, busy_o=0, return to IDLE.
  - ERROR: error_o=1, busy_o=0, return to IDLE.
- Throughput: exactly 512 mem_we_o pulses per sector, in ascending address order.
- Timeout: tmo is cleared on entry to WAIT_IDLE and WAIT_DONE and increments each cycle in those states. When tmo reaches TIMEOUT_CYCLES-1, go to ERROR and stop all SD and RAM activity.
- start_i while busy_o=1: ignored, no effect on the run in progress.
- Reset mid-load: the next cycle is the idle bus with no mem_we_o. Any SD transfer already in flight is left to complete; the next load recovers via CLR_DONE and WAIT_IDLE.

Decomposition:
- Package sd_boot_pkg holds:
  - the state enum;
  - SD register offsets: ADDR0=8'h00, BUSY=8'h04, RSTART=8'h05, PAGE=8'h07, DONE=8'h0A, BUF=8'h80;
  - PAGES=4 and PAGE_BYTES=128.
- Single module, no sub-module; the timeout counter stays inline.

Test Plan:
1. SD model holding sector 5 = byte i^0x5A; SECTOR_START=5, SECTOR_COUNT=1, LOAD_ADDR=0x0200; pulse start -> register writes 0x00..0x03 = 05,00,00,00; then one write to 0x05; 512 RAM writes 0x0200..0x03FF with data i^0x5A; done_o=1, busy_o=0.
2. SECTOR_COUNT=3, SECTOR_START=0x000000FF -> sector addresses 0xFF, 0x100, 0x101 written; 1536 contiguous RAM writes; exactly three writes to 0x05.
3. Model holds busy (reg 0x04 = 1) for 50 cycles, done latched at start -> no write to 0x05 before busy drops; stale done discarded, so the first accepted done follows the start.
4. TIMEOUT_CYCLES=100, model never raises done -> error_o=1 on cycle 100 of WAIT_DONE; no RAM writes; next start clears error_o.
5. LOAD_ADDR=0xFF00, one sector -> writes 0xFF00..0xFFFF, then 0x0000..0x00FF.
6. Reset asserted after 200 RAM writes, then restart with SECTOR_COUNT=0 -> outputs idle one cycle after reset; done_o=1 one cycle after start with no SD access.
